// File: rtl/ccu_pkg.sv
// Shared definitions for the crosswalk control unit: interval-timer state
// encoding and the default timer tick count agreed between ccu_top and the timer.
package ccu_pkg;

    localparam int CCU_TVALUE = 4;
    localparam int CCU_MULT_W = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        LOAD = ST_LOAD,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } timer_state_e;

endpackage

// File: rtl/ccu_tick_gen.sv
// Prescaler for the interval timer: one tick every TICK_DIV enabled cycles,
// restartable through clr. With TICK_DIV=1 every enabled cycle is a tick.
module ccu_tick_gen #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    generate
        if (TICK_DIV <= 1) begin : g_bypass
            logic unused_bypass;
            assign unused_bypass = ^{clk, reset, clr};
            assign tick = en;
        end else begin : g_div
            localparam int PW = $clog2(TICK_DIV);
            localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

            logic [PW-1:0] pre_reg;
            logic [PW-1:0] pre_next;

            always_comb begin
                pre_next = pre_reg;
                if (clr) begin
                    pre_next = '0;
                end else if (en) begin
                    pre_next = (pre_reg == LAST) ? '0 : pre_reg + PW'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    pre_reg <= '0;
                end else begin
                    pre_reg <= pre_next;
                end
            end

            assign tick = en && !clr && (pre_reg == LAST);
        end
    endgenerate

endmodule

// File: rtl/ccu_interval_timer.sv
// Restartable interval timer answering the ccu FSM: after tr falls it counts
// TICK_DIV*TVALUE*M cycles, then raises cf and holds it until the next tr.
module ccu_interval_timer
    import ccu_pkg::*;
#(
    parameter int TVALUE   = CCU_TVALUE,
    parameter int TICK_DIV = 1,
    localparam int CW      = $clog2(3 * TVALUE + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tr,
    input  logic [CCU_MULT_W-1:0] multiplier,
    output logic                  cf,
    output logic                  busy,
    output logic [CW-1:0]         remaining
);

    localparam logic [CW-1:0] TV = CW'(TVALUE);

    timer_state_e          state_reg, state_next;
    logic [CCU_MULT_W-1:0] m_reg, m_next;
    logic [CW-1:0]         count_reg, count_next;
    logic                  cf_reg, cf_next;
    logic                  busy_reg, busy_next;
    logic [CW-1:0]         remaining_reg, remaining_next;

    logic                  tick;
    logic                  tick_en;
    logic [CW-1:0]         load_value;

    // 3*TVALUE fits in CW bits by construction, so the product never wraps.
    assign load_value = TV * {{(CW - CCU_MULT_W){1'b0}}, multiplier};

    // The LOAD cycle already counts, so cf lands exactly on the product edge.
    assign tick_en = !tr && (((state_reg == LOAD) && (m_reg != '0)) ||
                             (state_reg == RUN));

    ccu_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) ccu_tick_gen_inst (
        .clk  (clk),
        .reset(reset),
        .clr  (tr),
        .en   (tick_en),
        .tick (tick)
    );

    always_comb begin
        state_next = state_reg;
        m_next     = m_reg;
        count_next = count_reg;

        if (tr) begin
            state_next = LOAD;
            m_next     = multiplier;
            count_next = load_value;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next = IDLE;
                end
                LOAD: begin
                    if (m_reg == '0) begin
                        state_next = DONE;
                        count_next = '0;
                    end else begin
                        state_next = RUN;
                        if (tick) begin
                            if (count_reg == CW'(1)) begin
                                state_next = DONE;
                                count_next = '0;
                            end else begin
                                count_next = count_reg - CW'(1);
                            end
                        end
                    end
                end
                RUN: begin
                    if (tick) begin
                        if (count_reg == CW'(1)) begin
                            state_next = DONE;
                            count_next = '0;
                        end else begin
                            count_next = count_reg - CW'(1);
                        end
                    end
                end
                DONE: begin
                    state_next = DONE;
                end
                default: begin
                    state_next = IDLE;
                    count_next = '0;
                end
            endcase
        end
    end

    // Outputs come straight from flops so proceed = cf & ~tr cannot glitch.
    always_comb begin
        cf_next        = (state_next == DONE);
        busy_next      = (state_next == RUN);
        remaining_next = '0;
        if ((state_next == LOAD) || (state_next == RUN)) begin
            remaining_next = count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            m_reg         <= '0;
            count_reg     <= '0;
            cf_reg        <= 1'b0;
            busy_reg      <= 1'b0;
            remaining_reg <= '0;
        end else begin
            state_reg     <= state_next;
            m_reg         <= m_next;
            count_reg     <= count_next;
            cf_reg        <= cf_next;
            busy_reg      <= busy_next;
            remaining_reg <= remaining_next;
        end
    end

    assign cf        = cf_reg;
    assign busy      = busy_reg;
    assign remaining = remaining_reg;

endmodule

// File: tb/tb_ccu_interval_timer.sv
// Directed bench for ccu_interval_timer: one instance without prescaler and
// one with TICK_DIV=3, both TVALUE=4, checked against hand-computed values.
module tb_ccu_interval_timer;

    logic       clk = 1'b0;
    logic       reset1, tr1;
    logic [1:0] m1;
    logic       cf1, busy1;
    logic [3:0] rem1;
    logic       reset3, tr3;
    logic [1:0] m3;
    logic       cf3, busy3;
    logic [3:0] rem3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ccu_interval_timer #(.TVALUE(4), .TICK_DIV(1)) dut (
        .clk       (clk),
        .reset     (reset1),
        .tr        (tr1),
        .multiplier(m1),
        .cf        (cf1),
        .busy      (busy1),
        .remaining (rem1)
    );

    ccu_interval_timer #(.TVALUE(4), .TICK_DIV(3)) dut3 (
        .clk       (clk),
        .reset     (reset3),
        .tr        (tr3),
        .multiplier(m3),
        .cf        (cf3),
        .busy      (busy3),
        .remaining (rem3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic check1(input string tag, input int ecf, input int ebusy, input int erem);
        check({tag, ".cf"}, int'(cf1), ecf);
        check({tag, ".busy"}, int'(busy1), ebusy);
        check({tag, ".rem"}, int'(rem1), erem);
    endtask

    task automatic check3(input string tag, input int ecf, input int ebusy, input int erem);
        check({tag, ".cf"}, int'(cf3), ecf);
        check({tag, ".busy"}, int'(busy3), ebusy);
        check({tag, ".rem"}, int'(rem3), erem);
    endtask

    initial begin
        reset1 = 1'b1; tr1 = 1'b0; m1 = 2'd0;
        reset3 = 1'b1; tr3 = 1'b0; m3 = 2'd0;

        // Reset then idle
        step(); step();
        check1("reset", 0, 0, 0);
        check3("reset3", 0, 0, 0);
        reset1 = 1'b0; reset3 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            check1("idle", 0, 0, 0);
        end
        $display("txn reset_idle done checks=%0d", checks);

        // Nominal interval, M=2 -> 8 edges; later multiplier changes are ignored
        tr1 = 1'b1; m1 = 2'd2;
        step();
        check1("nom.e0", 0, 0, 8);
        tr1 = 1'b0; m1 = 2'd3;
        for (int k = 1; k <= 8; k++) begin
            step();
            check1("nom.run", (k == 8) ? 1 : 0, (k < 8) ? 1 : 0, (k < 8) ? 8 - k : 0);
        end
        for (int k = 0; k < 50; k++) begin
            step();
            check1("nom.hold", 1, 0, 0);
        end
        $display("txn nominal done checks=%0d", checks);

        // Zero duration
        tr1 = 1'b1; m1 = 2'd0;
        step();
        check1("zero.e0", 0, 0, 0);
        tr1 = 1'b0;
        step();
        check1("zero.e1", 1, 0, 0);
        step();
        check1("zero.e2", 1, 0, 0);
        $display("txn zero done checks=%0d", checks);

        // Restart mid-run: M=3, 5 ticks, then M=1
        tr1 = 1'b1; m1 = 2'd3;
        step();
        check1("rst.e0", 0, 0, 12);
        tr1 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            check1("rst.first", 0, 1, 12 - k);
        end
        tr1 = 1'b1; m1 = 2'd1;
        step();
        check1("rst.e0b", 0, 0, 4);
        tr1 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            check1("rst.second", (k == 4) ? 1 : 0, (k < 4) ? 1 : 0, (k < 4) ? 4 - k : 0);
        end
        $display("txn restart done checks=%0d", checks);

        // Collision of terminal tick with tr, then tr held 6 cycles
        tr1 = 1'b1; m1 = 2'd1;
        step();
        check1("col.e0", 0, 0, 4);
        tr1 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            check1("col.run", 0, 1, 4 - k);
        end
        tr1 = 1'b1;
        step();
        check1("col.hit", 0, 0, 4);
        for (int k = 0; k < 5; k++) begin
            step();
            check1("col.held", 0, 0, 4);
        end
        tr1 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            check1("col.after", (k == 4) ? 1 : 0, (k < 4) ? 1 : 0, (k < 4) ? 4 - k : 0);
        end
        $display("txn collision done checks=%0d", checks);

        // Prescaler TICK_DIV=3, M=3 -> 36 edges
        tr3 = 1'b1; m3 = 2'd3;
        step();
        check3("div.e0", 0, 0, 12);
        tr3 = 1'b0;
        for (int k = 1; k <= 36; k++) begin
            step();
            check3("div.run", (k == 36) ? 1 : 0, (k < 36) ? 1 : 0, (k < 36) ? 12 - k / 3 : 0);
        end
        for (int k = 0; k < 5; k++) begin
            step();
            check3("div.hold", 1, 0, 0);
        end
        $display("txn prescaler done checks=%0d", checks);

        // Second run aborted by reset at edge 20
        tr3 = 1'b1; m3 = 2'd3;
        step();
        tr3 = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            step();
            check3("abort.run", 0, 1, 12 - k / 3);
        end
        reset3 = 1'b1;
        step();
        check3("abort.reset", 0, 0, 0);
        reset3 = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step();
            check3("abort.after", 0, 0, 0);
        end
        $display("txn reset_midop done checks=%0d", checks);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ccu_interval_timer.md
Name: ccu_interval_timer

Overview:
- Timing responder on the crosswalk control unit's timer interface; the ccu FSM is the initiator.
- The ccu FSM pulses tr and supplies a 2-bit multiplier. This block measures TICK_DIV*TVALUE*multiplier clock cycles, then raises cf and holds it until the next tr.
- It sits beside the ccu FSM inside ccu_top and replaces the generic counter with a protocol-exact, restartable timer that reports remaining time.

Parameters:
- TVALUE, 4, ticks per multiplier unit (>=1).
- TICK_DIV, 1, clock cycles per tick (>=1); the prescaler is bypassed when 1.
- CW, $clog2(3*TVALUE+1), width of the tick counter and the remaining output (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- tr  input  1  timer restart from ccu; level-sensitive; holds the timer cleared while high.
- multiplier  input  2  duration selector M, sampled only while tr=1.
- cf  output  1  count finished; level, held until the next tr.
- busy  output  1  high while a timed interval is in progress.
- remaining  output  CW  ticks left in the current interval; 0 when idle or done.

Behaviour:
- Reset (synchronous, takes priority over tr):
  - state=IDLE; cf=0; busy=0; remaining=0.
  - Prescaler and tick counter cleared; latched M=0.
- States: IDLE, LOAD, RUN, DONE.
- tr=1 in any state (after reset priority):
  - Next state is LOAD; multiplier is latched into M every cycle tr is high, so the last value seen wins.
  - Prescaler is cleared and tick counter is set to TVALUE*M.
  - cf=0 and busy=0 from the following edge.
- LOAD, tr=0:
  - M=0: go to DONE. cf is high one cycle after the last tr-high edge (minimum latency 1).
  - M>0: go to RUN; busy=1.
- RUN, tr=0:
  - Prescaler counts 0..TICK_DIV-1 and emits a tick on wrap.
  - Each tick decrements the tick counter.
  - When a tick arrives with counter==1: go to DONE, cf=1, busy=0, remaining=0.
- DONE: cf=1 is held indefinitely until tr or reset.
- IDLE: cf=0; nothing happens until tr.
- Latency: with E0 the last rising edge where tr=1, cf rises exactly max(1, TICK_DIV*TVALUE*M) edges after E0.
- Width rule: TVALUE*M is computed in CW bits; max value 3*TVALUE fits by construction; no overflow or wrap of the tick counter is permitted.
- Restart mid-interval: tr in RUN aborts the interval; the new M applies and no stale cf is produced.
- Simultaneous terminal tick and tr=1: tr wins; cf stays 0 and the timer reloads.
- tr held high for N cycles: the timer stays cleared, and counting starts on the first tr=0 cycle.
- multiplier changes while tr=0 are ignored.
- Outputs are registered; there is no combinational path from tr to cf, so the top-level proceed = cf & ~tr stays glitch-free.
- remaining mirrors the tick counter in RUN; it is 0 in IDLE, LOAD-with-M=0, and DONE.

Decomposition:
- Shared package ccu_pkg holds:
  - the state encoding localparams (IDLE/LOAD/RUN/DONE);
  - the default TVALUE, shared with ccu_top so both ends agree on timing.
- One sub-module, ccu_tick_gen: the prescaler with inputs clr and en and output tick, instantiated as ccu_tick_gen_inst. With TICK_DIV=1 it outputs tick=en.
- The FSM and tick counter stay in ccu_interval_timer.

Test Plan:
- Reset then idle: reset for 2 cycles, tr=0 for 20 cycles -> cf=0, busy=0, remaining=0 throughout.
- Nominal interval (TVALUE=4, TICK_DIV=1): tr=1 for 1 cycle with M=2 -> remaining=8 then counts down to 1; cf rises exactly 8 edges after the tr edge and stays high for 50 cycles with tr=0.
- Zero duration: tr pulse with M=0 -> cf=1 one edge later; busy never asserts.
- Restart mid-run: M=3 then, after 5 ticks, tr pulse with M=1 -> no cf during the first interval; cf rises 4 edges after the second tr.
- Collision and held tr: tr asserted on the same edge as the terminal tick -> cf stays 0. Then tr held high 6 cycles with M=1 -> cf rises 4 edges after the last tr-high edge.
- Prescaler and reset mid-op: TICK_DIV=3, M=3 -> cf after 36 edges; reset asserted at edge 20 of a second run -> all outputs 0 on the next edge, and no cf appears afterwards.
